// File: rtl/tcp_tx_session_shim.sv
// TCP TX session shim: keeps one request outstanding to the stack, retries with backoff
// while the stack reports no space, releases exactly the granted beats and reports status upstream.
module tcp_tx_session_shim #(
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned MAX_RETRY   = 16,
    parameter int unsigned BACKOFF_CYC = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [31:0]           s_meta_tdata,
    input  logic                  s_meta_tvalid,
    output logic                  s_meta_tready,

    input  logic [DATA_W-1:0]     s_data_tdata,
    input  logic [DATA_W/8-1:0]   s_data_tkeep,
    input  logic                  s_data_tvalid,
    output logic                  s_data_tready,

    output logic [31:0]           m_meta_tdata,
    output logic                  m_meta_tvalid,
    input  logic                  m_meta_tready,

    input  logic [63:0]           s_stat_tdata,
    input  logic                  s_stat_tvalid,
    output logic                  s_stat_tready,

    output logic [DATA_W-1:0]     m_data_tdata,
    output logic [DATA_W/8-1:0]   m_data_tkeep,
    output logic                  m_data_tlast,
    output logic                  m_data_tvalid,
    input  logic                  m_data_tready,

    output logic [31:0]           m_sts_tdata,
    output logic                  m_sts_tvalid,
    input  logic                  m_sts_tready
);

    localparam int unsigned BPB   = DATA_W / 8;
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
    localparam int unsigned BO_W  = $clog2(BACKOFF_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        STAT,
        BACKOFF,
        STREAM,
        DRAIN,
        REPORT
    } state_t;

    state_t state, state_nx;

    logic              alive;
    logic [15:0]       sid_q;
    logic [15:0]       len_q;
    logic [10:0]       rem_q;
    logic [RTY_W-1:0]  rty_q;
    logic [1:0]        err_q;
    logic [BO_W-1:0]   bo_q;

    logic [16:0]       len_round;
    logic [10:0]       beats_calc;
    logic [1:0]        st_err;
    logic [15:0]       st_sid;
    logic              sid_bad;
    logic              meta_hs;
    logic              up_hs;
    logic              last_beat;
    logic              rty_lt_max;
    logic              bo_done;
    logic              stat_unused;

    assign len_round   = 17'(s_meta_tdata[31:16]) + 17'(BPB - 1);
    assign beats_calc  = 11'(len_round / 17'(BPB));
    assign st_err      = s_stat_tdata[63:62];
    assign st_sid      = s_stat_tdata[15:0];
    assign stat_unused = ^s_stat_tdata[61:16];
    assign sid_bad     = (st_sid != sid_q);
    assign meta_hs     = s_meta_tvalid && alive && (state == IDLE);
    assign up_hs       = s_data_tvalid &&
                         (((state == STREAM) && m_data_tready) || (state == DRAIN));
    assign last_beat   = (rem_q == 11'd1);
    assign rty_lt_max  = (32'(rty_q) < MAX_RETRY);
    assign bo_done     = (32'(bo_q) == BACKOFF_CYC - 1);

    // Holds the upstream meta port closed for the first cycle out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) alive <= 1'b0;
        else          alive <= 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (meta_hs) begin
                    if (s_meta_tdata[31:16] == 16'd0) state_nx = REPORT;
                    else                              state_nx = REQ;
                end
            end
            REQ: begin
                if (m_meta_tready) state_nx = STAT;
            end
            STAT: begin
                if (s_stat_tvalid) begin
                    if (sid_bad)              state_nx = DRAIN;
                    else if (st_err == 2'b00) state_nx = STREAM;
                    else if (rty_lt_max)      state_nx = BACKOFF;
                    else                      state_nx = DRAIN;
                end
            end
            BACKOFF: begin
                if (bo_done) state_nx = REQ;
            end
            STREAM, DRAIN: begin
                if (up_hs && last_beat) state_nx = REPORT;
            end
            REPORT: begin
                if (m_sts_tready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sid_q <= '0;
            len_q <= '0;
            rem_q <= '0;
            rty_q <= '0;
            err_q <= '0;
            bo_q  <= '0;
        end else begin
            bo_q <= (state == BACKOFF) ? bo_q + 1'b1 : '0;
            if (meta_hs) begin
                sid_q <= s_meta_tdata[15:0];
                len_q <= s_meta_tdata[31:16];
                rem_q <= beats_calc;
                rty_q <= '0;
                err_q <= '0;
            end
            if ((state == STAT) && s_stat_tvalid) begin
                // A foreign sid overrides whatever error the stack reported.
                if (sid_bad) begin
                    err_q <= 2'b11;
                end else begin
                    err_q <= st_err;
                    if ((st_err != 2'b00) && rty_lt_max) rty_q <= rty_q + 1'b1;
                end
            end
            if (up_hs) rem_q <= rem_q - 11'd1;
        end
    end

    always_comb begin
        s_meta_tready = 1'b0;
        m_meta_tvalid = 1'b0;
        m_meta_tdata  = {len_q, sid_q};
        s_stat_tready = 1'b0;
        s_data_tready = 1'b0;
        m_data_tdata  = '0;
        m_data_tkeep  = '0;
        m_data_tlast  = 1'b0;
        m_data_tvalid = 1'b0;
        m_sts_tvalid  = 1'b0;
        m_sts_tdata   = {err_q, 14'(rty_q), sid_q};
        case (state)
            IDLE:    s_meta_tready = alive;
            REQ:     m_meta_tvalid = 1'b1;
            STAT:    s_stat_tready = 1'b1;
            STREAM: begin
                m_data_tvalid = s_data_tvalid;
                s_data_tready = m_data_tready;
                m_data_tdata  = s_data_tdata;
                m_data_tkeep  = s_data_tkeep;
                m_data_tlast  = last_beat;
            end
            DRAIN:   s_data_tready = 1'b1;
            REPORT:  m_sts_tvalid  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tcp_tx_session_shim.sv
// Directed bench for tcp_tx_session_shim: table of whole transactions with hand-computed
// outcomes, plus reset, stray-stat and mid-transfer reset sequences.
module tb_tcp_tx_session_shim;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int BO = 64;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [31:0]   s_meta_tdata;
    logic          s_meta_tvalid;
    logic          s_meta_tready;
    logic [DW-1:0] s_data_tdata;
    logic [KW-1:0] s_data_tkeep;
    logic          s_data_tvalid;
    logic          s_data_tready;
    logic [31:0]   m_meta_tdata;
    logic          m_meta_tvalid;
    logic          m_meta_tready;
    logic [63:0]   s_stat_tdata;
    logic          s_stat_tvalid;
    logic          s_stat_tready;
    logic [DW-1:0] m_data_tdata;
    logic [KW-1:0] m_data_tkeep;
    logic          m_data_tlast;
    logic          m_data_tvalid;
    logic          m_data_tready;
    logic [31:0]   m_sts_tdata;
    logic          m_sts_tvalid;
    logic          m_sts_tready;

    int tests = 0;
    int fails = 0;

    tcp_tx_session_shim #(
        .DATA_W      (DW),
        .MAX_RETRY   (16),
        .BACKOFF_CYC (BO)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_meta_tdata  (s_meta_tdata),
        .s_meta_tvalid (s_meta_tvalid),
        .s_meta_tready (s_meta_tready),
        .s_data_tdata  (s_data_tdata),
        .s_data_tkeep  (s_data_tkeep),
        .s_data_tvalid (s_data_tvalid),
        .s_data_tready (s_data_tready),
        .m_meta_tdata  (m_meta_tdata),
        .m_meta_tvalid (m_meta_tvalid),
        .m_meta_tready (m_meta_tready),
        .s_stat_tdata  (s_stat_tdata),
        .s_stat_tvalid (s_stat_tvalid),
        .s_stat_tready (s_stat_tready),
        .m_data_tdata  (m_data_tdata),
        .m_data_tkeep  (m_data_tkeep),
        .m_data_tlast  (m_data_tlast),
        .m_data_tvalid (m_data_tvalid),
        .m_data_tready (m_data_tready),
        .m_sts_tdata   (m_sts_tdata),
        .m_sts_tvalid  (m_sts_tvalid),
        .m_sts_tready  (m_sts_tready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] len;
        logic [15:0] sid;
        int          n_err;
        logic [1:0]  ecode;
        bit          bad_sid;
        bit          stall;
        int          exp_meta;
        int          exp_out;
        int          exp_drn;
        logic [31:0] exp_sts;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_word(input logic [15:0] sid, input int idx);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = {sid, 16'(idx)} ^ (32'(k) << 24);
        return w;
    endfunction

    function automatic logic [KW-1:0] beat_keep(input int idx);
        logic [KW-1:0] kp;
        kp = {(KW/8){8'(idx)}};
        return ~kp;
    endfunction

    task automatic clear_inputs();
        s_meta_tvalid = 1'b0;
        s_meta_tdata  = '0;
        s_data_tvalid = 1'b0;
        s_data_tdata  = '0;
        s_data_tkeep  = '0;
        s_stat_tvalid = 1'b0;
        s_stat_tdata  = '0;
        m_meta_tready = 1'b0;
        m_data_tready = 1'b0;
        m_sts_tready  = 1'b0;
    endtask

    // Cycle-level environment: inputs change at negedge, handshakes are judged at negedge+1.
    task automatic run_txn(input logic [15:0] len, input logic [15:0] sid, input int n_err,
                           input logic [1:0] ecode, input bit bad_sid, input bit stall,
                           input int abort_at,
                           output int n_meta, output int n_out, output int n_drn,
                           output logic [31:0] sts, output int min_gap, output int sts_lat,
                           output bit timeout);
        int  n_up, up_idx, attempt, acc_c, last_meta_c;
        bit  meta_pend, stat_pend, done;
        logic [1:0] serr;
        n_up = (int'(len) + 63) / 64;
        n_meta = 0; n_out = 0; n_drn = 0; sts = '0; min_gap = 1000000; sts_lat = -1;
        up_idx = 0; attempt = 0; acc_c = 0; last_meta_c = -1;
        meta_pend = 1'b1; stat_pend = 1'b0; done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge aclk);
            serr          = (attempt < n_err) ? ecode : 2'b00;
            s_meta_tvalid = meta_pend;
            s_meta_tdata  = {len, sid};
            s_stat_tvalid = stat_pend;
            s_stat_tdata  = {serr, 30'h1000, len, bad_sid ? (sid ^ 16'h000E) : sid};
            s_data_tvalid = (up_idx < n_up) && (!stall || $urandom_range(0, 3) != 0);
            s_data_tdata  = beat_word(sid, up_idx);
            s_data_tkeep  = beat_keep(up_idx);
            m_data_tready = !stall || ($urandom_range(0, 2) != 0);
            m_meta_tready = !stall || ($urandom_range(0, 1) != 0);
            m_sts_tready  = 1'b1;
            #1;
            if (s_meta_tvalid && s_meta_tready) begin
                meta_pend = 1'b0;
                acc_c = c;
            end
            if (s_stat_tvalid && s_stat_tready) begin
                stat_pend = 1'b0;
                attempt++;
            end
            if (m_meta_tvalid && m_meta_tready) begin
                check("meta_word", m_meta_tdata, {len, sid});
                if (last_meta_c >= 0 && (c - last_meta_c) < min_gap) min_gap = c - last_meta_c;
                last_meta_c = c;
                n_meta++;
                stat_pend = 1'b1;
            end
            if (m_data_tvalid && m_data_tready) begin
                tests++;
                if (m_data_tdata !== beat_word(sid, n_out)) begin
                    fails++;
                    $display("FAIL beat_data[%0d]: got 0x%0h expected 0x%0h", n_out,
                             m_data_tdata[31:0], beat_word(sid, n_out) & 512'hFFFF_FFFF);
                end
                check("beat_keep", m_data_tkeep, beat_keep(n_out));
                check("beat_tlast", m_data_tlast, n_out == n_up - 1);
                n_out++;
            end
            if (s_data_tvalid && s_data_tready) begin
                if (!m_data_tvalid) n_drn++;
                up_idx++;
            end
            if (m_sts_tvalid && m_sts_tready) begin
                sts = m_sts_tdata;
                sts_lat = c - acc_c;
                done = 1'b1;
            end
            if (abort_at != 0 && n_out == abort_at) done = 1'b1;
        end
        timeout = !done;
        @(posedge aclk);
        #1;
        if (abort_at == 0) clear_inputs();
    endtask

    int          n_meta, n_out, n_drn, min_gap, sts_lat, quiet;
    logic [31:0] sts;
    bit          timeout;

    initial begin
        vecs[0] = '{16'd128,   16'h0007,  0, 2'd0, 1'b0, 1'b0,  1,    2, 0, 32'h0000_0007};
        vecs[1] = '{16'd100,   16'h0003,  2, 2'd1, 1'b0, 1'b0,  3,    2, 0, 32'h0002_0003};
        vecs[2] = '{16'd200,   16'h0005, 17, 2'd1, 1'b0, 1'b0, 17,    0, 4, 32'h4010_0005};
        vecs[3] = '{16'd4096,  16'h0012,  0, 2'd0, 1'b0, 1'b1,  1,   64, 0, 32'h0000_0012};
        vecs[4] = '{16'd64,    16'h0007,  0, 2'd0, 1'b1, 1'b0,  1,    0, 1, 32'hC000_0007};
        vecs[5] = '{16'd0,     16'h0021,  0, 2'd0, 1'b0, 1'b0,  0,    0, 0, 32'h0000_0021};
        vecs[6] = '{16'd1,     16'h00AA,  1, 2'd2, 1'b0, 1'b0,  2,    1, 0, 32'h0001_00AA};
        vecs[7] = '{16'd65,    16'hBEEF,  0, 2'd0, 1'b0, 1'b1,  1,    2, 0, 32'h0000_BEEF};
        vecs[8] = '{16'hFFFF,  16'h0009,  3, 2'd3, 1'b0, 1'b0,  4, 1024, 0, 32'h0003_0009};
        vecs[9] = '{16'd64,    16'h0001, 17, 2'd2, 1'b0, 1'b0, 17,    0, 1, 32'h8010_0001};

        // Reset state with busy-looking inputs on every port.
        clear_inputs();
        s_data_tvalid = 1'b1;
        s_stat_tvalid = 1'b1;
        s_data_tdata  = '1;
        m_data_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_s_meta_tready", s_meta_tready, 0);
        check("rst_m_meta_tvalid", m_meta_tvalid, 0);
        check("rst_s_stat_tready", s_stat_tready, 0);
        check("rst_s_data_tready", s_data_tready, 0);
        check("rst_m_data_tvalid", m_data_tvalid, 0);
        check("rst_m_data_tdata",  m_data_tdata[63:0], 0);
        check("rst_m_data_tlast",  m_data_tlast, 0);
        check("rst_m_sts_tvalid",  m_sts_tvalid, 0);
        check("rst_m_meta_tdata",  m_meta_tdata, 0);
        check("rst_m_sts_tdata",   m_sts_tdata, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        check("idle_stray_stat_tready", s_stat_tready, 0);
        check("idle_data_tready", s_data_tready, 0);
        check("idle_meta_tready", s_meta_tready, 1);
        clear_inputs();

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].len, vecs[i].sid, vecs[i].n_err, vecs[i].ecode, vecs[i].bad_sid,
                    vecs[i].stall, 0, n_meta, n_out, n_drn, sts, min_gap, sts_lat, timeout);
            check($sformatf("v%0d_timeout", i), timeout, 0);
            check($sformatf("v%0d_meta_count", i), n_meta, vecs[i].exp_meta);
            check($sformatf("v%0d_out_beats", i), n_out, vecs[i].exp_out);
            check($sformatf("v%0d_drained", i), n_drn, vecs[i].exp_drn);
            check($sformatf("v%0d_status", i), sts, vecs[i].exp_sts);
            if (vecs[i].exp_meta > 1)
                check($sformatf("v%0d_backoff_gap_ok", i), min_gap >= BO, 1);
            if (vecs[i].len == 16'd0)
                check($sformatf("v%0d_len0_latency", i), sts_lat, 1);
        end

        // Reset after the third of eight beats has been handed over.
        run_txn(16'd512, 16'h0044, 0, 2'd0, 1'b0, 1'b0, 3,
                n_meta, n_out, n_drn, sts, min_gap, sts_lat, timeout);
        check("abort_reached_beat3", n_out, 3);
        #1;
        aresetn = 1'b0;
        #1;
        check("abort_m_data_tvalid", m_data_tvalid, 0);
        check("abort_s_data_tready", s_data_tready, 0);
        check("abort_m_meta_tvalid", m_meta_tvalid, 0);
        check("abort_m_sts_tvalid",  m_sts_tvalid, 0);
        check("abort_s_meta_tready", s_meta_tready, 0);
        clear_inputs();
        @(negedge aclk);
        aresetn = 1'b1;
        quiet = 0;
        m_sts_tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge aclk);
            #1;
            if (m_sts_tvalid || m_meta_tvalid || m_data_tvalid) quiet++;
        end
        check("abort_no_status_after", quiet, 0);
        clear_inputs();
        run_txn(16'd128, 16'h0055, 0, 2'd0, 1'b0, 1'b0, 0,
                n_meta, n_out, n_drn, sts, min_gap, sts_lat, timeout);
        check("post_reset_timeout", timeout, 0);
        check("post_reset_meta_count", n_meta, 1);
        check("post_reset_out_beats", n_out, 2);
        check("post_reset_status", sts, 32'h0000_0055);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
